wb_timer: RTL

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_timer.sv
`timescale 1ns/1ps
// Bus-mapped down-counter timer: CTRL/LOAD/COUNT/STATUS registers behind a
// single-cycle-ack strobe interface, prescaled tick, reload and level irq.
module wb_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        irq
);
  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, ACKS, HOLD} state_e;

  state_e        state_q;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          en_q, en_d;
  logic          reload_q, reload_d;
  logic          ie_q, ie_d;
  logic          exp_q, exp_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;

  logic          commit, wr, tick;
  logic          wr_ctrl, wr_load, wr_count, wr_status;
  logic [1:0]    sel;
  logic [31:0]   rdata;
  logic          unused_addr;

  assign unused_addr = ^{ADDR[31:4], ADDR[1:0]};

  assign sel       = ADDR[3:2];
  assign commit    = (state_q == IDLE) && STB;
  assign wr        = commit && WE;
  assign wr_ctrl   = wr && (sel == 2'd0);
  assign wr_load   = wr && (sel == 2'd1);
  assign wr_count  = wr && (sel == 2'd2);
  assign wr_status = wr && (sel == 2'd3);

  always_comb begin
    rdata = '0;
    case (sel)
      2'd0:    rdata = {29'd0, ie_q, reload_q, en_q};
      2'd1:    rdata = load_q;
      2'd2:    rdata = count_q;
      default: rdata = {31'd0, exp_q};
    endcase
  end

  // Bus FSM: only IDLE commits, so a long strobe yields exactly one ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (STB) begin
            state_q <= ACKS;
            ack_q   <= 1'b1;
            dat_q   <= WE ? 32'd0 : rdata;
          end else begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
          end
        end
        ACKS: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          state_q <= STB ? HOLD : IDLE;
        end
        HOLD: begin
          ack_q   <= 1'b0;
          dat_q   <= '0;
          if (!STB) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          dat_q   <= '0;
        end
      endcase
    end
  end

  assign tick = en_q && (pre_q == PRE_MAX);

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    exp_d    = exp_q;
    load_d   = load_q;
    count_d  = count_q;
    // Prescaler sits at 0 while disabled, so an EN 0->1 write starts a full period.
    pre_d    = (!en_q || tick) ? '0 : pre_q + PW'(1);

    // Clear first so a coincident expiry wins and EXP stays set.
    if (wr_status && DAT_I[0]) exp_d = 1'b0;

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (reload_q) count_d = load_q;
        else          en_d    = 1'b0;
      end
    end

    // Bus writes override the tick's effect on the same register.
    if (wr_ctrl) begin
      en_d     = DAT_I[0];
      reload_d = DAT_I[1];
      ie_d     = DAT_I[2];
    end
    if (wr_load)  load_d  = DAT_I;
    if (wr_count) count_d = DAT_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      pre_q    <= '0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
    end
  end

  assign ACK   = ack_q;
  assign DAT_O = dat_q;
  assign irq   = exp_q & ie_q;

endmodule
